decode_stage: RTL
=================

Name: decode_stage

Overview:
- Registered RV32I decode pipeline stage between instruction fetch and execute.
- Accepts one 32-bit instruction plus PC per valid/ready handshake and emits a compact opcode ID, instruction type and register indices.
- Also emits a fully assembled, sign-extended immediate and an illegal-instruction flag.
- Next-generation decoder: parametrised feature enables, backpressure, flush and full illegal-encoding detection.

Parameters:
- PC_W, 32, width of the PC carried alongside the instruction.
- ENABLE_CSR, 1, decode SYSTEM CSR ops (csrrw/s/c, csrrwi/si/ci); when 0 they flag illegal.
- ENABLE_FENCE, 1, decode fence/fence.i; when 0 they flag illegal.
- ENABLE_SYS, 1, decode ecall/ebreak; when 0 they flag illegal.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  discard the held output and any instruction presented this cycle.
- in_valid  in  1  instruction/PC valid.
- in_ready  out  1  stage can accept.
- in_instr  in  32  raw instruction.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts.
- out_op  out  6  rv32_op_e opcode ID (OP_ILLEGAL = 0).
- out_type  out  6  one-hot {b,j,u,s,i,r}; all-zero when illegal.
- out_rd, out_rs1, out_rs2  out  5 each  register indices; forced to 0 where the format has no such field.
- out_imm  out  32  sign-extended immediate (I/S/B/U/J); 0 for R-type. For csr*i, holds the zero-extended uimm[4:0].
- out_csr  out  12  instr[31:20] for CSR ops, else 0.
- out_illegal  out  1  unrecognised or disabled encoding.
- out_pc  out  PC_W  PC passthrough.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0. All other outputs are 0 (out_op=OP_ILLEGAL). in_ready=1 from the first cycle after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; no dependence on in_valid).
  - A transfer occurs when in_valid && in_ready. The decoded bundle appears on the next edge with out_valid=1. Latency 1 cycle, throughput 1 per cycle.
  - While out_valid && !out_ready, every out_* is held stable.
  - out_valid drops only on acceptance without a new input, or on flush.
- Flush:
  - flush=1 at an edge gives out_valid=0 on the next cycle.
  - An input presented in the same cycle is dropped, even though in_ready may read 1.
  - Flush beats both acceptance and new input.
- Decode is combinational on in_instr and is registered only on a transfer.
- Illegal (out_illegal=1, out_op=OP_ILLEGAL, out_type=0, indices and imm=0):
  - instr[1:0] != 2'b11.
  - Unlisted opcode[6:2].
  - Unlisted funct3 for branch, load or store.
  - R-type funct7 not 0000000, or 0100000 only with funct3 000/101.
  - slli/srli with funct7 != 0000000; srai with funct7 != 0100000.
  - SYSTEM funct3=100.
  - funct3=000 with imm other than 0/1, or with rd/rs1 != 0.
  - fence with funct3 other than 000/001, or rd/rs1 != 0.
  - Any encoding whose ENABLE_* parameter is 0.
- The illegal bundle is still delivered with out_valid=1 so execute can raise the exception. out_pc is valid for it.
- Immediates:
  - I: sext(instr[31:20]).
  - S: sext({[31:25],[11:7]}).
  - B: sext({[31],[7],[30:25],[11:8],1'b0}).
  - U: {[31:12],12'b0}.
  - J: sext({[31],[19:12],[20],[30:21],1'b0}).
  - All results are 32 bits exactly.
- sub and sra are distinguished by funct7=0100000.
- Reset mid-transfer: the pending bundle is lost and no partial outputs remain.

Decomposition:
- Package rv32_decode_pkg holds:
  - rv32_op_e (6-bit enum: OP_ILLEGAL=0, then the 47 RV32I/Zicsr/Zifencei ops in ISA-listing order).
  - Opcode[6:2] constants.
  - Type one-hot bit positions.
  - Imm format enum.
  - The struct dec_bundle_t {op, type, rd, rs1, rs2, imm, csr, illegal}.
- One combinational sub-module rv32_decode_comb (instr -> dec_bundle_t, takes the ENABLE_* parameters).
- decode_stage itself holds only the handshake, flush and output register.

Test Plan:
- Add/sub: in 0x002081B3 then 0x402081B3 back-to-back, out_ready=1 -> consecutive cycles give OP_ADD then OP_SUB, type r, rd=3, rs1=1, rs2=2, imm=0, 1-cycle latency each.
- Immediates:
  - 0xFFF00093 (addi x1,x0,-1) -> OP_ADDI, imm=0xFFFFFFFF, rs2=0.
  - 0x008000EF (jal x1,8) -> OP_JAL, type j, rd=1, imm=0x00000008.
- Backpressure: present 0x002081B3, hold out_ready=0 for 3 cycles with a second instruction waiting -> in_ready=0 and outputs stable all 3 cycles. On out_ready=1 the second instruction is accepted and appears the next cycle.
- Illegal:
  - 0x00000000 -> out_valid=1, out_illegal=1, OP_ILLEGAL, type 0.
  - With ENABLE_CSR=0, 0x30529073 -> illegal. With ENABLE_CSR=1 -> OP_CSRRW, rs1=5, out_csr=0x305.
- Flush: out_valid=1 held under out_ready=0, then flush=1 with in_valid=1 -> next cycle out_valid=0, and the flushed input never appears.
- Reset: assert rst_n=0 while out_valid=1 -> next cycle out_valid=0, out_op=0. After release, the first instruction decodes with 1-cycle latency.

Source files
------------

// File: rtl/rv32_decode_pkg.sv
// RV32I decode stage shared types: opcode IDs, major opcodes,
// immediate formats and the decoded bundle carried to execute.
package rv32_decode_pkg;

  typedef enum logic [5:0] {
    OP_ILLEGAL = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_FENCE, OP_ECALL, OP_EBREAK, OP_FENCE_I,
    OP_CSRRW, OP_CSRRS, OP_CSRRC,
    OP_CSRRWI, OP_CSRRSI, OP_CSRRCI
  } rv32_op_e;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  localparam int T_R = 0;
  localparam int T_I = 1;
  localparam int T_S = 2;
  localparam int T_U = 3;
  localparam int T_J = 4;
  localparam int T_B = 5;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z
  } imm_fmt_e;

  typedef struct packed {
    rv32_op_e    op;
    logic [5:0]  itype;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [11:0] csr;
    logic        illegal;
  } dec_bundle_t;

endpackage

// File: rtl/rv32_decode_comb.sv
// Combinational RV32I/Zicsr/Zifencei decoder: raw instruction to
// decoded bundle, with optional instruction groups.
module rv32_decode_comb
  import rv32_decode_pkg::*;
#(
  parameter bit ENABLE_CSR   = 1'b1,
  parameter bit ENABLE_FENCE = 1'b1,
  parameter bit ENABLE_SYS   = 1'b1
) (
  input  logic [31:0] instr,
  output dec_bundle_t dec
);

  logic [4:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        f7_zero;
  logic        f7_alt;
  logic        rr_zero;
  rv32_op_e    op;
  imm_fmt_e    fmt;
  logic [31:0] imm;
  logic        legal;
  logic        use_rd;
  logic        use_rs1;
  logic        use_rs2;

  assign opc     = instr[6:2];
  assign f3      = instr[14:12];
  assign f7      = instr[31:25];
  assign rd      = instr[11:7];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign f7_zero = (f7 == 7'b0000000);
  assign f7_alt  = (f7 == 7'b0100000);
  assign rr_zero = (rd == 5'd0) && (rs1 == 5'd0);

  always_comb begin
    op  = OP_ILLEGAL;
    fmt = IMM_NONE;
    unique case (1'b1)
      (opc == OPC_LUI): begin
        op  = OP_LUI;
        fmt = IMM_U;
      end
      (opc == OPC_AUIPC): begin
        op  = OP_AUIPC;
        fmt = IMM_U;
      end
      (opc == OPC_JAL): begin
        op  = OP_JAL;
        fmt = IMM_J;
      end
      (opc == OPC_JALR): begin
        fmt = IMM_I;
        if (f3 == 3'b000) op = OP_JALR;
      end
      (opc == OPC_BRANCH): begin
        fmt = IMM_B;
        unique case (f3)
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_BLT;
          3'b101:  op = OP_BGE;
          3'b110:  op = OP_BLTU;
          3'b111:  op = OP_BGEU;
          default: op = OP_ILLEGAL;
        endcase
      end
      (opc == OPC_LOAD): begin
        fmt = IMM_I;
        unique case (f3)
          3'b000:  op = OP_LB;
          3'b001:  op = OP_LH;
          3'b010:  op = OP_LW;
          3'b100:  op = OP_LBU;
          3'b101:  op = OP_LHU;
          default: op = OP_ILLEGAL;
        endcase
      end
      (opc == OPC_STORE): begin
        fmt = IMM_S;
        unique case (f3)
          3'b000:  op = OP_SB;
          3'b001:  op = OP_SH;
          3'b010:  op = OP_SW;
          default: op = OP_ILLEGAL;
        endcase
      end
      (opc == OPC_OP_IMM): begin
        fmt = IMM_I;
        unique case (f3)
          3'b000: op = OP_ADDI;
          3'b010: op = OP_SLTI;
          3'b011: op = OP_SLTIU;
          3'b100: op = OP_XORI;
          3'b110: op = OP_ORI;
          3'b111: op = OP_ANDI;
          3'b001: op = f7_zero ? OP_SLLI : OP_ILLEGAL;
          default: begin
            if (f7_zero)     op = OP_SRLI;
            else if (f7_alt) op = OP_SRAI;
          end
        endcase
      end
      (opc == OPC_OP): begin
        if (f7_zero) begin
          unique case (f3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
          endcase
        end else if (f7_alt) begin
          if (f3 == 3'b000)      op = OP_SUB;
          else if (f3 == 3'b101) op = OP_SRA;
        end
      end
      (opc == OPC_MISC_MEM): begin
        fmt = IMM_I;
        if (ENABLE_FENCE && rr_zero) begin
          if (f3 == 3'b000)      op = OP_FENCE;
          else if (f3 == 3'b001) op = OP_FENCE_I;
        end
      end
      (opc == OPC_SYSTEM): begin
        fmt = IMM_I;
        unique case (f3)
          3'b000: begin
            if (ENABLE_SYS && rr_zero) begin
              if (instr[31:20] == 12'd0)      op = OP_ECALL;
              else if (instr[31:20] == 12'd1) op = OP_EBREAK;
            end
          end
          3'b001: if (ENABLE_CSR) op = OP_CSRRW;
          3'b010: if (ENABLE_CSR) op = OP_CSRRS;
          3'b011: if (ENABLE_CSR) op = OP_CSRRC;
          3'b101: if (ENABLE_CSR) op = OP_CSRRWI;
          3'b110: if (ENABLE_CSR) op = OP_CSRRSI;
          3'b111: if (ENABLE_CSR) op = OP_CSRRCI;
          default: op = OP_ILLEGAL;
        endcase
        if (f3[2] && (f3[1:0] != 2'b00)) fmt = IMM_Z;
      end
      default: op = OP_ILLEGAL;
    endcase
  end

  always_comb begin
    imm = '0;
    unique case (fmt)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};
      IMM_Z: imm = {27'b0, instr[19:15]};
      default: imm = '0;
    endcase
  end

  assign legal   = (op != OP_ILLEGAL) && (instr[1:0] == 2'b11);
  assign use_rd  = (fmt != IMM_S) && (fmt != IMM_B);
  assign use_rs1 = (fmt == IMM_NONE) || (fmt == IMM_I) ||
                   (fmt == IMM_S) || (fmt == IMM_B);
  assign use_rs2 = (fmt == IMM_NONE) || (fmt == IMM_S) ||
                   (fmt == IMM_B);

  always_comb begin
    dec = '0;
    if (!legal) begin
      dec.illegal = 1'b1;
    end else begin
      dec.op  = op;
      dec.rd  = use_rd  ? rd  : 5'd0;
      dec.rs1 = use_rs1 ? rs1 : 5'd0;
      dec.rs2 = use_rs2 ? rs2 : 5'd0;
      dec.imm = imm;
      if (op >= OP_CSRRW) dec.csr = instr[31:20];
      unique case (fmt)
        IMM_NONE:     dec.itype[T_R] = 1'b1;
        IMM_S:        dec.itype[T_S] = 1'b1;
        IMM_B:        dec.itype[T_B] = 1'b1;
        IMM_U:        dec.itype[T_U] = 1'b1;
        IMM_J:        dec.itype[T_J] = 1'b1;
        default:      dec.itype[T_I] = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: valid/ready handshake, flush and
// output register around the combinational decoder.
module decode_stage
  import rv32_decode_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter bit ENABLE_CSR   = 1'b1,
  parameter bit ENABLE_FENCE = 1'b1,
  parameter bit ENABLE_SYS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_op,
  output logic [5:0]      out_type,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [31:0]     out_imm,
  output logic [11:0]     out_csr,
  output logic            out_illegal,
  output logic [PC_W-1:0] out_pc
);

  dec_bundle_t     dec;
  dec_bundle_t     q;
  logic [PC_W-1:0] pc_q;
  logic            valid_q;
  logic            take;

  rv32_decode_comb #(
    .ENABLE_CSR  (ENABLE_CSR),
    .ENABLE_FENCE(ENABLE_FENCE),
    .ENABLE_SYS  (ENABLE_SYS)
  ) u_comb (
    .instr(in_instr),
    .dec  (dec)
  );

  assign in_ready = !valid_q || out_ready;
  assign take     = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      q       <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (take) begin
      valid_q <= 1'b1;
      q       <= dec;
      pc_q    <= in_pc;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign out_op      = q.op;
  assign out_type    = q.itype;
  assign out_rd      = q.rd;
  assign out_rs1     = q.rs1;
  assign out_rs2     = q.rs2;
  assign out_imm     = q.imm;
  assign out_csr     = q.csr;
  assign out_illegal = q.illegal;
  assign out_pc      = pc_q;

endmodule
